// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
//   Single-issue execute stage. Simple ALU operations finish in one cycle. The
//   multiply/divide operations (MUL, MULHU, DIVU, REMU) use an iterative unit:
//   shift-add for multiply, restoring division for divide. It runs for WORD
//   cycles and then holds its result until downstream accepts it.
//
// Parameters
//   WORD      datapath width; a power of two, 8 or greater
//   ADDR_LEN  PC width
//   MDU_EN    1 enables the iterative multiply/divide unit. When it is 0,
//             opcodes 10-13 return 0 in a single cycle.
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  upstream handshake; an op transfers when both are high
//   opsel1, opsel2       operand A / operand B source selects
//   alu_func             operation code
//   rs1_value, rs2_value, imm, pc_i
//                        source operands and the PC of the op
//   out_valid / out_ready
//                        downstream handshake
//   alu_out, pc_o        result and the PC captured with the op
//   busy                 high while a multiply/divide iterates
// -----------------------------------------------------------------------------
module execute_stage #(
  parameter int WORD     = 32,
  parameter int ADDR_LEN = 32,
  parameter bit MDU_EN   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          opsel1,
  input  logic [1:0]          opsel2,
  input  logic [3:0]          alu_func,
  input  logic [WORD-1:0]     rs1_value,
  input  logic [WORD-1:0]     rs2_value,
  input  logic [WORD-1:0]     imm,
  input  logic [ADDR_LEN-1:0] pc_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD-1:0]     alu_out,
  output logic [ADDR_LEN-1:0] pc_o,
  output logic                busy
);

  localparam int SW = $clog2(WORD);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t            state, state_next;
  logic [WORD-1:0]   pc_word;
  logic [WORD-1:0]   op_a, op_b, alu_res;
  logic [SW-1:0]     shamt;
  logic              accept, is_mdu, last_iter;

  // Iterative unit state. For multiply, hi accumulates the upper product and
  // lo shifts the multiplier out as product bits shift in. For divide, hi is
  // the partial remainder and lo shifts the dividend out as quotient bits
  // shift in.
  logic [WORD-1:0]   hi, lo, opb_m;
  logic              is_div, sel_hi;
  logic [SW-1:0]     cnt;
  logic [WORD:0]     mul_sum, rem_sh;
  logic              fits;
  logic [WORD-1:0]   hi_next, lo_next, mdu_res;

  // Fit the PC to the datapath width by zero-extending or truncating it.
  if (ADDR_LEN >= WORD) begin : g_pc_trunc
    assign pc_word = pc_i[WORD-1:0];
  end else begin : g_pc_ext
    assign pc_word = {{(WORD-ADDR_LEN){1'b0}}, pc_i};
  end

  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state == BUSY);
  assign last_iter = (cnt == SW'(WORD - 1));
  assign is_mdu    = MDU_EN && (alu_func >= 4'd10) && (alu_func <= 4'd13);

  // Operand selection and the single-cycle ALU.
  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    op_a = '0;
    case (opsel1)
      2'd0:    op_a = rs1_value;
      2'd1:    op_a = pc_word;
      default: op_a = '0;
    endcase

    op_b = '0;
    case (opsel2)
      2'd0:    op_b = rs2_value;
      2'd1:    op_b = imm;
      2'd2:    op_b = WORD'(4);
      default: op_b = '0;
    endcase

    shamt   = op_b[SW-1:0];
    alu_res = '0;
    case (alu_func)
      4'd0:    alu_res = op_a + op_b;
      4'd1:    alu_res = op_a - op_b;
      4'd2:    alu_res = op_a & op_b;
      4'd3:    alu_res = op_a | op_b;
      4'd4:    alu_res = op_a ^ op_b;
      4'd5:    alu_res = op_a << shamt;
      4'd6:    alu_res = op_a >> shamt;
      4'd7:    alu_res = WORD'($signed(op_a) >>> shamt);
      4'd8:    alu_res = WORD'($signed(op_a) < $signed(op_b));
      4'd9:    alu_res = WORD'(op_a < op_b);
      default: alu_res = '0;  // reserved opcodes, and MDU ops when MDU_EN=0
    endcase
  end

  // One step of the iterative unit.
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opb_m} : '0);
    rem_sh  = {hi, lo[WORD-1]};
    fits    = (rem_sh >= {1'b0, opb_m});
    hi_next = hi;
    lo_next = lo;
    if (is_div) begin
      // The new remainder is always below the divisor, so WORD bits are enough.
      // With a zero divisor every step "fits": the quotient becomes all-ones
      // and the remainder ends up equal to the dividend.
      hi_next = fits ? (rem_sh[WORD-1:0] - opb_m) : rem_sh[WORD-1:0];
      lo_next = {lo[WORD-2:0], fits};
    end else begin
      hi_next = mul_sum[WORD:1];
      lo_next = {mul_sum[0], lo[WORD-1:1]};
    end
    mdu_res = sel_hi ? hi_next : lo_next;
  end

  // State register.
  // NOTE: sequential blocks use non-blocking assignments. Every flop then
  // samples values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && is_mdu) state_next = BUSY;
      BUSY:    if (last_iter)        state_next = HOLD;
      HOLD:    if (out_ready)        state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      alu_out   <= '0;
      pc_o      <= '0;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      opb_m     <= '0;
      is_div    <= 1'b0;
      sel_hi    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Draining and accepting can happen on the same edge. The accept
          // branch below overrides the clear for a single-cycle op.
          if (out_ready) out_valid <= 1'b0;
          if (accept) begin
            pc_o <= pc_i;
            if (is_mdu) begin
              // Opcodes 10..13 are 4'b1010..4'b1101. Bit 2 picks divide and
              // bit 0 picks the high half (MULHU) or the remainder (REMU).
              is_div <= alu_func[2];
              sel_hi <= alu_func[0];
              cnt    <= '0;
              hi     <= '0;
              if (alu_func[2]) begin
                lo    <= op_a;
                opb_m <= op_b;
              end else begin
                lo    <= op_b;
                opb_m <= op_a;
              end
            end else begin
              alu_out   <= alu_res;
              out_valid <= 1'b1;
            end
          end
        end
        BUSY: begin
          hi  <= hi_next;
          lo  <= lo_next;
          cnt <= cnt + SW'(1);
          if (last_iter) begin
            alu_out   <= mdu_res;
            out_valid <= 1'b1;
            cnt       <= '0;
          end
        end
        HOLD: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// -----------------------------------------------------------------------------
// tb_execute_stage
//   Self-checking bench for execute_stage (WORD=32, ADDR_LEN=32, MDU_EN=1).
//   Directed scenarios and a randomized run. The randomized run compares the
//   DUT against a scoreboard fed by a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_execute_stage;

  logic        clk, reset;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0]  opsel1, opsel2;
  logic [3:0]  alu_func;
  logic [31:0] rs1_value, rs2_value, imm, pc_i, alu_out, pc_o;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] res;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];

  execute_stage #(.WORD(32), .ADDR_LEN(32), .MDU_EN(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opsel1    (opsel1),
    .opsel2    (opsel2),
    .alu_func  (alu_func),
    .rs1_value (rs1_value),
    .rs2_value (rs2_value),
    .imm       (imm),
    .pc_i      (pc_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .pc_o      (pc_o),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the summary line");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_op_a(input logic [1:0] s, input logic [31:0] r1,
                                             input logic [31:0] pc);
    if (s == 2'd0)      return r1;
    else if (s == 2'd1) return pc;
    else                return 32'd0;
  endfunction

  function automatic logic [31:0] model_op_b(input logic [1:0] s, input logic [31:0] r2,
                                             input logic [31:0] im);
    case (s)
      2'd0:    return r2;
      2'd1:    return im;
      2'd2:    return 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_result(input int f, input logic [31:0] a,
                                               input logic [31:0] b);
    logic [63:0] p;
    int unsigned sh;
    sh = b % 32;
    p  = 64'(a) * 64'(b);
    case (f)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return a << sh;
      6:  return a >> sh;
      7:  return a[31] ? ~((~a) >> sh) : (a >> sh);
      8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      9:  return (a < b) ? 32'd1 : 32'd0;
      10: return p[31:0];
      11: return p[63:32];
      12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      13: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input int f, input logic [1:0] s1, input logic [1:0] s2,
                          input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] im, input logic [31:0] pc);
    in_valid  = 1'b1;
    alu_func  = f[3:0];
    opsel1    = s1;
    opsel2    = s2;
    rs1_value = r1;
    rs2_value = r2;
    imm       = im;
    pc_i      = pc;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset     = 1'b1;
    out_ready = 1'b0;
    drive_op(0, 2'd0, 2'd0, $urandom, $urandom, $urandom, $urandom);
    repeat (3) step();
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (alu_out !== 32'd0) begin miscompares++; $display("FAIL reset_alu_out: got %h want 0", alu_out); end
    vectors++; if (pc_o !== 32'd0) begin miscompares++; $display("FAIL reset_pc_o: got %h want 0", pc_o); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    drive_op(0, 2'd0, 2'd0, 32'd4, 32'd2, 32'd0, 32'd1);
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL add_in_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL add_out_valid: got %b want 1", out_valid); end
    vectors++; if (alu_out !== 32'd6) begin miscompares++; $display("FAIL add_result: got %h want 6", alu_out); end
    vectors++; if (pc_o !== 32'd1) begin miscompares++; $display("FAIL add_pc_o: got %h want 1", pc_o); end
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL add_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive_op(1, 2'd0, 2'd0, 32'd4, 32'd6, 32'd0, 32'h10);
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready0: got %b want 1", in_ready); end
    step();
    drive_op(7, 2'd0, 2'd1, 32'h8000_0000, 32'd0, 32'd4, 32'h14);
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready1: got %b want 1", in_ready); end
    vectors++; if (alu_out !== 32'hFFFF_FFFE || out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_sub: got %h/%b want fffffffe/1", alu_out, out_valid); end
    step();
    in_valid = 1'b0;
    vectors++; if (alu_out !== 32'hF800_0000 || out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_sra: got %h/%b want f8000000/1", alu_out, out_valid); end
    vectors++; if (pc_o !== 32'h14) begin miscompares++; $display("FAIL b2b_pc_o: got %h want 14", pc_o); end
    step();
  endtask

  task automatic test_mdu();
    int          f_tab[6]   = '{10, 11, 12, 13, 12, 13};
    logic [31:0] a_tab[6]   = '{32'h1_0000, 32'h1_0000, 32'd100, 32'd100, 32'd5, 32'd5};
    logic [31:0] b_tab[6]   = '{32'h1_0000, 32'h1_0000, 32'd7, 32'd7, 32'd0, 32'd0};
    logic [31:0] exp_tab[6] = '{32'd0, 32'd1, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      int lat, bcnt;
      drive_op(f_tab[i], 2'd0, 2'd0, a_tab[i], b_tab[i], 32'd0, 32'h100 + i);
      step();
      in_valid = 1'b0;
      lat  = 1;
      bcnt = 0;
      while (!out_valid && lat < 100) begin
        if (busy) bcnt++;
        rs1_value = $urandom;  // must be ignored while iterating
        rs2_value = $urandom;
        step();
        lat++;
      end
      vectors++; if (lat !== 33) begin miscompares++; $display("FAIL mdu%0d_latency: got %0d want 33", i, lat); end
      vectors++; if (bcnt !== 32) begin miscompares++; $display("FAIL mdu%0d_busy_cycles: got %0d want 32", i, bcnt); end
      vectors++; if (alu_out !== exp_tab[i]) begin miscompares++; $display("FAIL mdu%0d_result: got %h want %h", i, alu_out, exp_tab[i]); end
      vectors++; if (pc_o !== 32'h100 + i || busy !== 1'b0) begin miscompares++; $display("FAIL mdu%0d_pc_busy: got %h/%b want %h/0", i, pc_o, busy, 32'h100 + i); end
      step();
      vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL mdu%0d_drain: got valid %b ready %b want 0/1", i, out_valid, in_ready); end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive_op(0, 2'd0, 2'd0, 32'd10, 32'd20, 32'd0, 32'h1234);
    step();
    drive_op(0, 2'd0, 2'd0, 32'd7, 32'd8, 32'd0, 32'h2000);
    for (int c = 0; c < 5; c++) begin
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp%0d_in_ready: got %b want 0", c, in_ready); end
      vectors++; if (out_valid !== 1'b1 || alu_out !== 32'd30) begin miscompares++; $display("FAIL bp%0d_hold: got %b/%h want 1/1e", c, out_valid, alu_out); end
      vectors++; if (pc_o !== 32'h1234) begin miscompares++; $display("FAIL bp%0d_pc_o: got %h want 1234", c, pc_o); end
      step();
    end
    out_ready = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || alu_out !== 32'd15 || pc_o !== 32'h2000) begin miscompares++; $display("FAIL bp_new_op: got %b/%h/%h want 1/f/2000", out_valid, alu_out, pc_o); end
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_busy();
    int rises;
    out_ready = 1'b1;
    drive_op(12, 2'd0, 2'd0, 32'd1000, 32'd3, 32'd0, 32'h40);
    step();
    in_valid = 1'b0;
    repeat (9) step();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rb_busy_c10: got %b want 1", busy); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++; if (busy !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL rb_after_reset: got busy %b valid %b want 0/0", busy, out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rb_in_ready: got %b want 1", in_ready); end
    rises = 0;
    repeat (40) begin
      if (out_valid) rises++;
      step();
    end
    vectors++; if (rises !== 0) begin miscompares++; $display("FAIL rb_no_result: got %0d valid cycles want 0", rises); end
    drive_op(0, 2'd0, 2'd0, 32'd1, 32'd1, 32'd0, 32'h44);
    step();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || alu_out !== 32'd2) begin miscompares++; $display("FAIL rb_add: got %b/%h want 1/2", out_valid, alu_out); end
    step();
  endtask

  task automatic test_random();
    exp_t        e;
    logic        was_stalled;
    logic [31:0] prev_out, prev_pc;
    was_stalled = 1'b0;
    prev_out    = '0;
    prev_pc     = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int f;
      logic [31:0] r2;
      out_ready = ($urandom_range(0, 3) != 0);
      if (cyc >= 500) begin
        in_valid = 1'b0;
      end else begin
        if ($urandom_range(0, 3) == 0) f = $urandom_range(10, 13);
        else begin
          f = $urandom_range(0, 11);
          if (f >= 10) f = f + 4;
        end
        case ($urandom_range(0, 3))
          0:       r2 = 32'd0;
          1:       r2 = $urandom_range(1, 40);
          default: r2 = $urandom;
        endcase
        drive_op(f, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 $urandom, r2, $urandom, $urandom);
        in_valid = ($urandom_range(0, 2) != 0);
      end
      #1;
      if (was_stalled) begin
        vectors++;
        if (out_valid !== 1'b1 || alu_out !== prev_out || pc_o !== prev_pc) begin
          miscompares++;
          $display("FAIL rnd_hold cyc %0d: got %b/%h/%h want 1/%h/%h", cyc, out_valid, alu_out, pc_o, prev_out, prev_pc);
        end
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL rnd_unexpected cyc %0d: got result %h want none", cyc, alu_out);
        end else begin
          e = sb.pop_front();
          if (alu_out !== e.res || pc_o !== e.pc) begin
            miscompares++;
            $display("FAIL rnd_result cyc %0d: got %h/%h want %h/%h", cyc, alu_out, pc_o, e.res, e.pc);
          end
        end
      end
      if (in_valid && in_ready) begin
        e.res = model_result(int'(alu_func), model_op_a(opsel1, rs1_value, pc_i),
                             model_op_b(opsel2, rs2_value, imm));
        e.pc  = pc_i;
        sb.push_back(e);
      end
      was_stalled = out_valid && !out_ready;
      prev_out    = alu_out;
      prev_pc     = pc_o;
      step();
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL rnd_leftover: got %0d pending results want 0", sb.size());
    end
  endtask

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    test_reset();
    test_add();
    test_back_to_back();
    test_mdu();
    test_backpressure();
    test_reset_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
